// File: rtl/softmax_vector_packer.sv
// softmax_vector_packer: collects a stream of signed Q2.14 elements into an
// N-lane vector for the softmax pipeline. Short vectors (closed by i_last) are
// padded with the most negative value so a downstream max is unaffected.
// Optional feature: define PACKER_RUNNING_MAX_EN to add the o_max output
// (signed running maximum of the real elements of each vector).
module softmax_vector_packer #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [BIT_WIDTH-1:0]   i_elem,
  input  logic                   i_last,
  output logic                   o_ready,
  input  logic                   i_hold,
  output logic [N*BIT_WIDTH-1:0] o_data,
  output logic                   o_valid,
  output logic [$clog2(N):0]     o_count
`ifdef PACKER_RUNNING_MAX_EN
  ,
  output logic signed [BIT_WIDTH-1:0] o_max
`endif
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;
  // Most negative two's-complement value; neutral element for a max.
  localparam logic [BIT_WIDTH-1:0] PAD = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             accept;
  logic             closing;
  logic             emit;

  assign o_ready = (state_reg == S_FILL);
  assign accept  = i_valid && o_ready;
  // i_last only matters when qualified by an accepted element.
  assign closing = accept && ((idx_reg == IDX_W'(N-1)) || i_last);
  assign emit    = (state_reg == S_EMIT) && !i_hold;

  // Next-state logic for the FILL/EMIT controller, lane index and count.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    if (accept) begin
      idx_next   = idx_reg + IDX_W'(1);
      count_next = count_reg + CNT_W'(1);
      if (closing) state_next = S_EMIT;
    end
    if (emit) begin
      idx_next   = '0;
      count_next = '0;
      state_next = S_FILL;
    end
  end

  // Controller state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_FILL;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  // Output strobe and element count, registered at the emit edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_count <= '0;
    end else begin
      o_valid <= emit;
      if (emit) o_count <= count_reg;
    end
  end

  // Lane storage doubles as the output register; lanes above the closing
  // element are padded on the same edge the vector closes.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [BIT_WIDTH-1:0] lane_reg;

      // Capture the element for this lane, or pad it when the vector closes early.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          lane_reg <= '0;
        end else if (accept && (idx_reg == IDX_W'(gi))) begin
          lane_reg <= i_elem;
        end else if (closing && (IDX_W'(gi) > idx_reg)) begin
          lane_reg <= PAD;
        end
      end

      assign o_data[gi*BIT_WIDTH +: BIT_WIDTH] = lane_reg;
    end
  endgenerate

`ifdef PACKER_RUNNING_MAX_EN
  logic signed [BIT_WIDTH-1:0] max_reg, max_next;

  // Signed running max over accepted elements; reloads PAD after each emit.
  always_comb begin
    max_next = max_reg;
    if (accept && ($signed(i_elem) > max_reg)) max_next = $signed(i_elem);
    if (emit) max_next = $signed(PAD);
  end

  // Running max register and its output copy, published with o_valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      max_reg <= $signed(PAD);
      o_max   <= '0;
    end else begin
      max_reg <= max_next;
      if (emit) o_max <= max_reg;
    end
  end
`else
  // Without the running-max option the data path carries no comparator.
`endif

endmodule

// File: tb/tb_softmax_vector_packer.sv
// Directed testbench for softmax_vector_packer (default build, N=8, 16-bit).
module tb_softmax_vector_packer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [15:0]  i_elem;
  logic         i_last;
  logic         o_ready;
  logic         i_hold;
  logic [127:0] o_data;
  logic         o_valid;
  logic [3:0]   o_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_v [8];

  always #5 i_clk = ~i_clk;

  softmax_vector_packer #(.BIT_WIDTH(16), .N(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_elem  (i_elem),
    .i_last  (i_last),
    .o_ready (o_ready),
    .i_hold  (i_hold),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_count (o_count)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int k);
    return o_data[k*16 +: 16];
  endfunction

  task automatic check_lanes(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_lane%0d", tag, k), 32'(lane(k)), 32'(exp_v[k]));
  endtask

  task automatic check_vec(input string tag, input int cnt);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_count"}, 32'(o_count), 32'(cnt));
    check_lanes(tag);
    $display("vector %s: o_valid=%0d o_count=%0d data=%h", tag, o_valid, o_count, o_data);
  endtask

  task automatic feed(input logic [15:0] e, input logic last);
    i_valid = 1'b1;
    i_elem  = e;
    i_last  = last;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    logic [15:0] full_v [8];
    int sent;
    int p1;
    int p2;
    full_v = '{16'h6000, 16'hF000, 16'h3000, 16'h7FFF,
               16'hC000, 16'h4000, 16'h0000, 16'hE000};

    // Reset
    i_rst = 1'b1; i_valid = 1'b0; i_elem = '0; i_last = 1'b0; i_hold = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    for (int k = 0; k < 8; k++) exp_v[k] = 16'h0000;
    check_lanes("rst");

    // Full vector, back-to-back, no hold
    for (int k = 0; k < 8; k++) feed(full_v[k], 1'b0);
    check("full_emit_ready", 32'(o_ready), 32'd0);
    check("full_emit_valid", 32'(o_valid), 32'd0);
    tick();
    exp_v = full_v;
    check_vec("full", 8);
    tick();
    check("full_pulse_end", 32'(o_valid), 32'd0);
    check("full_ready_back", 32'(o_ready), 32'd1);

    // Short vector closed by i_last
    feed(16'h1000, 1'b0);
    feed(16'h2000, 1'b0);
    feed(16'h0800, 1'b1);
    check("short_emit_ready", 32'(o_ready), 32'd0);
    tick();
    exp_v = '{16'h1000, 16'h2000, 16'h0800, 16'h8000,
              16'h8000, 16'h8000, 16'h8000, 16'h8000};
    check_vec("short", 3);
    tick();

    // Backpressure: hold asserted as EMIT is entered, 5 cycles
    for (int k = 0; k < 8; k++) begin
      exp_v[k] = 16'(16'h0111 * (k + 1));
      feed(exp_v[k], 1'b0);
    end
    i_hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_ready", c), 32'(o_ready), 32'd0);
      check($sformatf("hold%0d_valid", c), 32'(o_valid), 32'd0);
      check_lanes($sformatf("hold%0d", c));
    end
    i_hold = 1'b0;
    tick();
    check_vec("hold_release", 8);
    tick();
    check("hold_pulse_end", 32'(o_valid), 32'd0);

    // Reset mid-fill, asserted between clock edges
    for (int k = 0; k < 4; k++) feed(16'(16'h0A00 + k), 1'b0);
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_valid", 32'(o_valid), 32'd0);
    for (int k = 0; k < 8; k++) exp_v[k] = 16'h0000;
    check_lanes("arst");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tick();
    check("arst_no_valid", 32'(o_valid), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      exp_v[k] = 16'(16'h5000 + k);
      feed(exp_v[k], 1'b0);
      if (k < 7) check($sformatf("arst_fill%0d_ready", k), 32'(o_ready), 32'd1);
    end
    tick();
    check_vec("post_rst", 8);
    tick();

    // i_last without i_valid is ignored
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    check("lone_last_ready", 32'(o_ready), 32'd1);
    check("lone_last_valid", 32'(o_valid), 32'd0);

    // i_last on the first element
    feed(16'h1234, 1'b1);
    check("single_emit_ready", 32'(o_ready), 32'd0);
    tick();
    exp_v = '{16'h1234, 16'h8000, 16'h8000, 16'h8000,
              16'h8000, 16'h8000, 16'h8000, 16'h8000};
    check_vec("single", 1);
    tick();

    // Two consecutive full vectors: pulses 9 cycles apart
    sent = 0; p1 = -1; p2 = -1;
    for (int c = 0; c < 30; c++) begin
      if (o_ready && sent < 16) begin
        i_valid = 1'b1;
        i_elem  = 16'(sent * 16'h0101);
        sent++;
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (o_valid) begin
        if (p1 < 0) p1 = c;
        else if (p2 < 0) p2 = c;
        $display("pulse at cycle %0d count=%0d lane0=%h", c, o_count, lane(0));
      end
    end
    i_valid = 1'b0;
    check("b2b_first_pulse", 32'(p1), 32'd8);
    check("b2b_gap", 32'(p2 - p1), 32'd9);
    for (int k = 0; k < 8; k++) exp_v[k] = 16'((k + 8) * 16'h0101);
    check_lanes("b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
